adrv9001_tdd_sched: RTL and testbench

//  Frame-based TDD scheduler for the ADRV9001 channel enables, in the s_axi_aclk domain.
//  A free-running frame counter runs once started. Each channel enable (rx1, rx2, tx1, tx2)
//  is asserted inside a programmable on/off window of every frame. Outputs are ORed into
//  the per-channel tdd_en inputs of the rx/tx datapaths, alongside the register and PL enables.

---
 rtl/adrv9001_tdd_sched_pkg.sv | 20 ++
 rtl/adrv9001_tdd_sched_if.sv | 32 +++
 rtl/adrv9001_tdd_sched_win.sv | 48 ++++
 rtl/adrv9001_tdd_sched.sv | 116 +++++++++++
 tb/tb_adrv9001_tdd_sched.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adrv9001_tdd_sched_pkg.sv
// Shared types and constants for the ADRV9001 TDD scheduler.
// Latency: none here. Backpressure: not applicable.
package adrv9001_tdd_pkg;

    localparam int TDD_CNT_W  = 24;
    localparam int TDD_NUM_CH = 4;

    localparam int CH_RX1 = 0;
    localparam int CH_RX2 = 1;
    localparam int CH_TX1 = 2;
    localparam int CH_TX2 = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } tdd_state_t;

endpackage

// File: rtl/adrv9001_tdd_sched_if.sv
// Control/status bundle between the TDD scheduler and whoever programs it.
// Latency: wires only. Backpressure: none, pulses are fire-and-forget.
interface adrv9001_tdd_sched_if #(
    parameter int CNT_W  = 24,
    parameter int NUM_CH = 4
);
    logic                    start;
    logic                    stop;
    logic                    sync_mode;
    logic                    sync_ext;
    logic [CNT_W-1:0]        frame_len;
    logic [31:0]             num_frames;
    logic [NUM_CH-1:0]       ch_mask;
    logic [NUM_CH*CNT_W-1:0] ch_on;
    logic [NUM_CH*CNT_W-1:0] ch_off;
    logic [NUM_CH-1:0]       tdd_en;
    logic                    frame_start;
    logic [31:0]             frame_cnt;
    logic [1:0]              state;
    logic                    busy;
    logic                    done;

    modport master (
        output start, stop, sync_mode, sync_ext, frame_len, num_frames, ch_mask, ch_on, ch_off,
        input  tdd_en, frame_start, frame_cnt, state, busy, done
    );

    modport slave (
        input  start, stop, sync_mode, sync_ext, frame_len, num_frames, ch_mask, ch_on, ch_off,
        output tdd_en, frame_start, frame_cnt, state, busy, done
    );
endinterface

// File: rtl/adrv9001_tdd_sched_win.sv
// Per-channel on/off window with shadowed config, reloaded only at frame boundaries.
// Latency: 1 cycle from counter to tdd_en. Backpressure: none.
module adrv9001_tdd_win #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic             cfg_mask,
    input  logic             reload,
    input  logic             run,
    output logic             tdd_en
);
    logic [CNT_W-1:0] on_sh;
    logic [CNT_W-1:0] off_sh;
    logic             mask_sh;
    logic             hit;

    // off == len is a legal "until end of frame"; anything beyond the frame disables the channel
    always_comb begin
        hit = 1'b0;
        if (mask_sh && (on_sh < len) && (off_sh <= len) && (on_sh != off_sh)) begin
            if (on_sh < off_sh)
                hit = (cnt >= on_sh) && (cnt < off_sh);
            else
                hit = (cnt >= on_sh) || (cnt < off_sh);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            on_sh   <= '0;
            off_sh  <= '0;
            mask_sh <= 1'b0;
            tdd_en  <= 1'b0;
        end else begin
            if (reload) begin
                on_sh   <= cfg_on;
                off_sh  <= cfg_off;
                mask_sh <= cfg_mask;
            end
            tdd_en <= run && hit;
        end
    end
endmodule

// File: rtl/adrv9001_tdd_sched.sv
// Frame-based TDD scheduler driving the ADRV9001 rx/tx channel enables.
// Latency: tdd_en/frame_start 1 cycle behind the frame counter. Backpressure: none.
module adrv9001_tdd_sched
    import adrv9001_tdd_pkg::*;
#(
    parameter int CNT_W  = TDD_CNT_W,
    parameter int NUM_CH = TDD_NUM_CH
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    adrv9001_tdd_sched_if.slave  bus
);
    tdd_state_t        st;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len_sh;
    logic [CNT_W-1:0]  len_in;
    logic [31:0]       nfr_sh;
    logic [31:0]       fcnt;
    logic              stop_pend;
    logic              sync_q;
    logic              busy_q;
    logic              done_q;
    logic              fs_q;
    logic [NUM_CH-1:0] en_w;

    logic run, wrap, sync_rise, start_acc, reload, last;

    assign len_in    = (bus.frame_len < CNT_W'(2)) ? CNT_W'(2) : bus.frame_len;
    assign run       = (st == ST_RUN);
    assign wrap      = run && (cnt == len_sh - CNT_W'(1));
    assign sync_rise = bus.sync_ext && !sync_q;
    assign start_acc = (st == ST_IDLE) && bus.start && !bus.stop;
    assign reload    = start_acc || wrap;
    // a stop landing on the wrap cycle itself ends at this boundary
    assign last      = wrap && (((nfr_sh != 32'd0) && (fcnt + 32'd1 == nfr_sh)) || stop_pend || bus.stop);

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            st          <= ST_IDLE;
            cnt         <= '0;
            len_sh      <= CNT_W'(2);
            nfr_sh      <= '0;
            fcnt        <= '0;
            stop_pend   <= 1'b0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            sync_q <= bus.sync_ext;
            done_q <= 1'b0;
            fs_q   <= run && (cnt == '0);
            if (reload)
                len_sh <= len_in;
            case (st)
                ST_IDLE: begin
                    if (start_acc) begin
                        fcnt      <= '0;
                        nfr_sh    <= bus.num_frames;
                        stop_pend <= 1'b0;
                        cnt       <= '0;
                        busy_q    <= 1'b1;
                        st        <= bus.sync_mode ? ST_ARMED : ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (bus.stop) begin
                        st     <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (sync_rise) begin
                        st <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop)
                        stop_pend <= 1'b1;
                    if (wrap) begin
                        cnt  <= '0;
                        fcnt <= fcnt + 32'd1;
                        if (last) begin
                            st        <= ST_DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            stop_pend <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        adrv9001_tdd_win #(.CNT_W(CNT_W)) u_win (
            .clk      (s_axi_aclk),
            .rst      (s_axi_areset),
            .cnt      (cnt),
            .len      (len_sh),
            .cfg_on   (bus.ch_on[i*CNT_W +: CNT_W]),
            .cfg_off  (bus.ch_off[i*CNT_W +: CNT_W]),
            .cfg_mask (bus.ch_mask[i]),
            .reload   (reload),
            .run      (run),
            .tdd_en   (en_w[i])
        );
    end

    assign bus.tdd_en      = en_w;
    assign bus.frame_start = fs_q;
    assign bus.frame_cnt   = fcnt;
    assign bus.state       = st;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_adrv9001_tdd_sched.sv
// Scoreboard bench: stimulus queues expected frame windows and status snapshots, monitors check them.
module tb_adrv9001_tdd_sched;
    import adrv9001_tdd_pkg::*;

    localparam int CW = TDD_CNT_W;
    localparam int NC = TDD_NUM_CH;

    typedef logic [NC-1:0][31:0] pat_t;
    typedef struct {
        pat_t        pat;
        logic [31:0] fcnt;
        logic        done;
    } frm_t;
    typedef struct {
        string       name;
        logic [1:0]  st;
        logic        busy;
        logic [NC-1:0] en;
        logic        fs;
        logic        done;
        logic [31:0] fcnt;
    } stat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adrv9001_tdd_sched_if #(.CNT_W(CW), .NUM_CH(NC)) bus();

    adrv9001_tdd_sched #(.CNT_W(CW), .NUM_CH(NC)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus)
    );

    frm_t  frm_q[$];
    stat_t stat_q[$];
    frm_t  fe;
    stat_t se;
    pat_t  cur;
    pat_t  p;
    int    vectors = 0;
    int    miscompares = 0;
    int    mon_len = 10;
    bit    mon_en = 1'b1;
    bit    capt = 1'b0;
    bit    at_end;
    int    pos = 0;

    // frame monitor: pos p of a frame holds the window result for counter value p
    always @(negedge clk) begin
        if (!mon_en) begin
            capt = 1'b0;
        end else begin
            if (bus.frame_start) begin
                capt = 1'b1;
                pos  = 0;
                cur  = '0;
            end
            at_end = capt && (pos == mon_len - 1);
            if (bus.done && !at_end) begin
                vectors++;
                miscompares++;
                $display("FAIL done_spurious: done=1 at pos %0d, want done only at frame end", pos);
            end
            if (capt) begin
                for (int c = 0; c < NC; c++) cur[c][pos] = bus.tdd_en[c];
                if (at_end) begin
                    capt = 1'b0;
                    vectors++;
                    if (frm_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_unexpected: got frame fcnt=%0d, want no frame", bus.frame_cnt);
                    end else begin
                        fe = frm_q.pop_front();
                        if (cur !== fe.pat || bus.frame_cnt !== fe.fcnt || bus.done !== fe.done) begin
                            miscompares++;
                            $display("FAIL frame: got pat=%h fcnt=%0d done=%b, want pat=%h fcnt=%0d done=%b",
                                     cur, bus.frame_cnt, bus.done, fe.pat, fe.fcnt, fe.done);
                        end
                    end
                end else begin
                    pos++;
                end
            end
        end
    end

    // status monitor: snapshots are queued just after a posedge and checked at the next negedge
    always @(negedge clk) begin
        if (stat_q.size() != 0) begin
            se = stat_q.pop_front();
            vectors++;
            if (bus.state !== se.st || bus.busy !== se.busy || bus.tdd_en !== se.en ||
                bus.frame_start !== se.fs || bus.done !== se.done || bus.frame_cnt !== se.fcnt) begin
                miscompares++;
                $display("FAIL %s: got st=%0d busy=%b en=%h fs=%b done=%b fcnt=%0d, want st=%0d busy=%b en=%h fs=%b done=%b fcnt=%0d",
                         se.name, bus.state, bus.busy, bus.tdd_en, bus.frame_start, bus.done, bus.frame_cnt,
                         se.st, se.busy, se.en, se.fs, se.done, se.fcnt);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_stat(input string nm, input logic [1:0] st, input logic busy,
                            input logic [NC-1:0] en, input logic fs, input logic dn, input logic [31:0] fc);
        stat_t s;
        s.name = nm; s.st = st; s.busy = busy; s.en = en; s.fs = fs; s.done = dn; s.fcnt = fc;
        stat_q.push_back(s);
    endtask

    task automatic exp_frames(input pat_t pt, input int n, input int first_fc, input bit last_done);
        frm_t f;
        for (int k = 0; k < n; k++) begin
            f.pat  = pt;
            f.fcnt = 32'(first_fc + k);
            f.done = last_done && (k == n - 1);
            frm_q.push_back(f);
        end
    endtask

    task automatic set_ch(input int ch, input int on, input int off, input bit m);
        bus.ch_on[ch*CW +: CW]  = CW'(on);
        bus.ch_off[ch*CW +: CW] = CW'(off);
        bus.ch_mask[ch]         = m;
    endtask

    task automatic setup(input int len, input int nfr, input bit smode);
        bus.frame_len  = CW'(len);
        bus.num_frames = 32'(nfr);
        bus.sync_mode  = smode;
        bus.ch_mask    = '0;
        bus.ch_on      = '0;
        bus.ch_off     = '0;
        mon_len        = len;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (bus.state !== ST_IDLE && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: state=%0d after %0d cycles, want IDLE", nm, bus.state, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.sync_ext = 1'b0;
        setup(10, 0, 1'b0);
        tick(3);
        exp_stat("reset", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: rx1 window 2..4, three frames
        setup(10, 3, 1'b0);
        set_ch(CH_RX1, 2, 5, 1'b1);
        p = '0; p[CH_RX1] = 32'h1C;
        exp_frames(p, 3, 1, 1'b1);
        pulse_start();
        exp_stat("t1_run", ST_RUN, 1'b1, '0, 1'b0, 1'b0, 32'd0);
        wait_idle("t1", 100);
        exp_stat("t1_idle", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd3);
        tick(2);

        // 2: tx1 window wrapping across the frame boundary
        setup(10, 2, 1'b0);
        set_ch(CH_TX1, 8, 2, 1'b1);
        p = '0; p[CH_TX1] = 32'h303;
        exp_frames(p, 2, 1, 1'b1);
        pulse_start();
        exp_stat("t2_run", ST_RUN, 1'b1, '0, 1'b0, 1'b0, 32'd0);
        wait_idle("t2", 100);
        exp_stat("t2_idle", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd2);
        tick(2);

        // 3: sync mode, full-frame window (off == len)
        setup(10, 1, 1'b1);
        set_ch(CH_RX1, 0, 10, 1'b1);
        p = '0; p[CH_RX1] = 32'h3FF;
        exp_frames(p, 1, 1, 1'b1);
        pulse_start();
        exp_stat("t3_armed", ST_ARMED, 1'b1, '0, 1'b0, 1'b0, 32'd0);
        tick(10);
        exp_stat("t3_armed10", ST_ARMED, 1'b1, '0, 1'b0, 1'b0, 32'd0);
        tick(9);
        bus.sync_ext = 1'b1;
        tick();
        exp_stat("t3_run", ST_RUN, 1'b1, '0, 1'b0, 1'b0, 32'd0);
        tick();
        exp_stat("t3_c0", ST_RUN, 1'b1, 4'b0001, 1'b1, 1'b0, 32'd0);
        tick(3);
        bus.sync_ext = 1'b0;
        wait_idle("t3", 100);
        exp_stat("t3_idle", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd1);
        tick(2);

        // 4: unlimited run, graceful stop at c=4 of frame 5
        setup(8, 0, 1'b0);
        set_ch(CH_RX2, 1, 3, 1'b1);
        p = '0; p[CH_RX2] = 32'h06;
        exp_frames(p, 6, 1, 1'b1);
        pulse_start();
        tick(44);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_idle("t4", 100);
        exp_stat("t4_idle", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd6);
        tick(3);
        exp_stat("t4_after", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd6);
        tick(2);

        // 5: mid-frame config changes take effect at the next frame; disabled cases stay low
        setup(10, 6, 1'b0);
        set_ch(CH_RX2, 1, 4, 1'b1);
        p = '0; p[CH_RX2] = 32'h0E;  exp_frames(p, 1, 1, 1'b0);
        p = '0; p[CH_RX2] = 32'h1C0; exp_frames(p, 1, 2, 1'b0);
        p = '0;                      exp_frames(p, 4, 3, 1'b1);
        pulse_start();
        tick(5);  set_ch(CH_RX2, 6, 9, 1'b1);
        tick(10); set_ch(CH_RX2, 3, 3, 1'b1);
        tick(10); set_ch(CH_RX2, 10, 2, 1'b1);
        tick(10); set_ch(CH_RX2, 2, 11, 1'b1);
        tick(10); set_ch(CH_RX2, 1, 4, 1'b0);
        wait_idle("t5", 100);
        exp_stat("t5_idle", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd6);
        tick(2);

        // 6: reset mid-run, then start+stop together from IDLE
        mon_en = 1'b0;
        setup(4, 0, 1'b0);
        for (int c = 0; c < NC; c++) set_ch(c, 0, 4, 1'b1);
        pulse_start();
        tick(6);
        exp_stat("t6_run", ST_RUN, 1'b1, 4'hF, 1'b0, 1'b0, 32'd1);
        rst = 1'b1;
        tick();
        exp_stat("t6_rst", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        exp_stat("t6_ss", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        tick(3);
        exp_stat("t6_ss_hold", ST_IDLE, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        tick(3);

        while (frm_q.size() != 0) begin
            fe = frm_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL frame_missing: got no frame, want fcnt=%0d pat=%h", fe.fcnt, fe.pat);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
